// File: rtl/stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : stream_packer
// Purpose  : Packs RATIO consecutive IN_WIDTH-bit words into one output word,
//            lane 0 first. Define STREAM_PACKER_LAST_EN for in_last/out_keep/out_last.
// Revision : 1.0
// ============================================================================
module stream_packer #(
    parameter int IN_WIDTH = 32,
    parameter int RATIO    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_WIDTH-1:0]       in_data,
`ifdef STREAM_PACKER_LAST_EN
    input  logic                      in_last,
    output logic [RATIO-1:0]          out_keep,
    output logic                      out_last,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IN_WIDTH*RATIO-1:0] out_data
);

    localparam int               OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int               CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(RATIO - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [OUT_WIDTH-1:0] data_q,  data_d;
    logic                 in_fire;
    logic                 out_fire;
    logic                 word_last;
    logic                 complete;
`ifdef STREAM_PACKER_LAST_EN
    logic [RATIO-1:0]     keep_q,  keep_d;
    logic                 last_q,  last_d;

    assign word_last = in_last;
    assign out_keep  = keep_q;
    assign out_last  = last_q;
`else
    assign word_last = 1'b0;
`endif

    assign out_valid = (state_q == HOLD);
    assign in_ready  = ~out_valid | out_ready;
    assign out_data  = data_q;

    always_comb begin
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
        complete = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
`ifdef STREAM_PACKER_LAST_EN
        keep_d   = keep_q;
        last_d   = last_q;
`endif

        if (out_fire) begin
            state_d = FILL;
            data_d  = '0;
`ifdef STREAM_PACKER_LAST_EN
            keep_d  = '0;
            last_d  = 1'b0;
`endif
        end

        if (in_fire) begin
            // A word landing in lane 0 starts a fresh output; stale lanes must read 0.
            if (cnt_q == '0) begin
                data_d = '0;
`ifdef STREAM_PACKER_LAST_EN
                keep_d = '0;
`endif
            end
            for (int k = 0; k < RATIO; k++) begin
                if (cnt_q == k[CNT_W-1:0]) begin
                    data_d[k*IN_WIDTH +: IN_WIDTH] = in_data;
`ifdef STREAM_PACKER_LAST_EN
                    keep_d[k] = 1'b1;
`endif
                end
            end
            complete = (cnt_q == CNT_MAX) | word_last;
            if (complete) begin
                state_d = HOLD;
                cnt_d   = '0;
`ifdef STREAM_PACKER_LAST_EN
                last_d  = word_last;
`endif
            end else begin
                state_d = FILL;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef STREAM_PACKER_LAST_EN
            keep_q  <= '0;
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef STREAM_PACKER_LAST_EN
            keep_q  <= keep_d;
            last_q  <= last_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_stream_packer
// Purpose  : Self-checking bench for stream_packer (cycle table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_stream_packer;

    localparam int IW = 32;
    localparam int R  = 4;
    localparam int OW = IW * R;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [IW-1:0] in_data   = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [OW-1:0] out_data;
`ifdef STREAM_PACKER_LAST_EN
    logic          in_last   = 1'b0;
    logic [R-1:0]  out_keep;
    logic          out_last;
`endif

    typedef struct {
        logic [OW-1:0] data;
        logic [R-1:0]  keep;
        logic          last;
    } exp_t;

    typedef struct {
        logic          iv;
        logic [IW-1:0] id;
        logic          ordy;
        logic          ov;
        logic          ir;
        logic          cod;
        logic [OW-1:0] od;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    exp_t          sb_q[$];
    vec_t          vecs[$];
    int            out_times[$];
    bit            sb_en    = 1'b0;
    bit            chk_ir   = 1'b0;
    bit            rnd_done = 1'b0;
    int            m_cnt    = 0;
    logic [OW-1:0] m_data   = '0;
    logic [R-1:0]  m_keep   = '0;

    stream_packer #(
        .IN_WIDTH (IW),
        .RATIO    (R)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef STREAM_PACKER_LAST_EN
        .in_last   (in_last),
        .out_keep  (out_keep),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic iv, input logic [IW-1:0] id, input logic ordy,
                           input logic ov, input logic ir, input logic cod, input logic [OW-1:0] od);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.ov = ov; v.ir = ir; v.cod = cod; v.od = od;
        vecs.push_back(v);
    endtask

    // Reference packer: builds the expected output word from accepted inputs.
    task automatic model_accept(input logic [IW-1:0] d, input logic last);
        exp_t e;
        bit   done;
        if (m_cnt == 0) begin
            m_data = '0;
            m_keep = '0;
        end
        m_data[m_cnt*IW +: IW] = d;
        m_keep[m_cnt]          = 1'b1;
        done = (m_cnt == R - 1);
`ifdef STREAM_PACKER_LAST_EN
        done = done | last;
`endif
        if (done) begin
            e.data = m_data; e.keep = m_keep; e.last = last;
            sb_q.push_back(e);
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Caller must be aligned at posedge+1; returns aligned at posedge+1 after acceptance.
    task automatic send_word(input logic [IW-1:0] d, input logic last);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
`ifdef STREAM_PACKER_LAST_EN
        in_last  = last;
`endif
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                model_accept(d, last);
                acc = 1'b1;
            end
            sync();
        end
        in_valid = 1'b0;
`ifdef STREAM_PACKER_LAST_EN
        in_last  = 1'b0;
`endif
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word 0x%0h not accepted, required acceptance within 200 cycles", d);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
        checki("sb_drained", sb_q.size(), 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_en && chk_ir) check1("in_ready_sustained", in_ready, 1'b1);
            if (sb_en && out_valid === 1'b1 && out_ready === 1'b1) begin
                out_times.push_back(cyc);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%0h expected no output", out_data);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data", out_data, e.data);
`ifdef STREAM_PACKER_LAST_EN
                    check("sb_keep", OW'(out_keep), OW'(e.keep));
                    check1("sb_last", out_last, e.last);
`endif
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check1("rst_in_ready", in_ready, 1'b1);
`ifdef STREAM_PACKER_LAST_EN
        check("rst_out_keep", OW'(out_keep), '0);
        check1("rst_out_last", out_last, 1'b0);
`endif
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check1("post_rst_in_ready", in_ready, 1'b1);
        check1("post_rst_out_valid", out_valid, 1'b0);

        // Cycle table: inputs of a cycle and the outputs seen in that same cycle
        add_vec(1, 32'h11, 1, 0, 1, 0, '0);
        add_vec(1, 32'h22, 1, 0, 1, 0, '0);
        add_vec(1, 32'h33, 1, 0, 1, 0, '0);
        add_vec(1, 32'h44, 1, 0, 1, 0, '0);
        add_vec(0, 32'h0,  1, 1, 1, 1, 128'h00000044_00000033_00000022_00000011);
        add_vec(0, 32'h0,  1, 0, 1, 1, '0);
        for (int i = 1; i <= 4; i++) add_vec(1, IW'(i), 0, 0, 1, 0, '0);
        for (int i = 0; i < 5; i++)  add_vec(1, 32'h55, 0, 1, 0, 1, 128'h00000004_00000003_00000002_00000001);
        add_vec(1, 32'h55, 1, 1, 1, 1, 128'h00000004_00000003_00000002_00000001);
        add_vec(1, 32'h66, 1, 0, 1, 0, '0);
        add_vec(1, 32'h77, 1, 0, 1, 0, '0);
        add_vec(1, 32'h88, 1, 0, 1, 0, '0);
        add_vec(0, 32'h0,  1, 1, 1, 1, 128'h00000088_00000077_00000066_00000055);
        add_vec(0, 32'h0,  1, 0, 1, 1, '0);
        foreach (vecs[i]) begin
            sync();
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            @(negedge clk);
            check1($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
            check1($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].ir);
            if (vecs[i].cod) check($sformatf("vec%0d_out_data", i), out_data, vecs[i].od);
        end

        // Continuous stream 1..12: three outputs four cycles apart, no in_ready drop
        out_ready = 1'b1;
        sb_en     = 1'b1;
        sync();
        out_times.delete();
        chk_ir = 1'b1;
        for (int i = 1; i <= 12; i++) send_word(IW'(i), 1'b0);
        repeat (6) @(negedge clk);
        chk_ir = 1'b0;
        checki("stream_out_count", out_times.size(), 3);
        if (out_times.size() == 3) begin
            checki("stream_gap0", out_times[1] - out_times[0], R);
            checki("stream_gap1", out_times[2] - out_times[1], R);
        end
        wait_drain();

        // Random downstream back-pressure
        sync();
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
`ifdef STREAM_PACKER_LAST_EN
                    send_word(IW'($urandom), ($urandom_range(0, 3) == 0));
`else
                    send_word(IW'($urandom), 1'b0);
`endif
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 1) == 1);
                    sync();
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        if (m_cnt != 0) begin
            sync();
            for (int i = m_cnt; i < R; i++) send_word(IW'(32'hF0 + i), 1'b0);
            wait_drain();
        end

        // Reset after two of four words discards the partial word
        sync();
        send_word(32'hDEAD0001, 1'b0);
        send_word(32'hDEAD0002, 1'b0);
        rst_n = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        check1("midfill_rst_out_valid", out_valid, 1'b0);
        check1("midfill_rst_in_ready", in_ready, 1'b1);
        check("midfill_rst_out_data", out_data, '0);
        sync();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("midfill_post_rst_valid", out_valid, 1'b0);
        end
        sync();
        for (int i = 0; i < R; i++) send_word(IW'(32'h100 + i), 1'b0);
        wait_drain();

        // Reset while holding a full word discards it
        sync();
        out_ready = 1'b0;
        for (int i = 0; i < R; i++) send_word(IW'(32'h200 + i), 1'b0);
        rst_n = 1'b0;
        if (sb_q.size() != 0) void'(sb_q.pop_back());
        @(negedge clk);
        check1("hold_rst_out_valid", out_valid, 1'b0);
        check("hold_rst_out_data", out_data, '0);
        sync();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("hold_post_rst_valid", out_valid, 1'b0);
        end

`ifdef STREAM_PACKER_LAST_EN
        // Partial flush by in_last after two words
        sync();
        send_word(32'hA, 1'b0);
        send_word(32'hB, 1'b1);
        @(negedge clk);
        check("flush2_keep", OW'(out_keep), OW'(4'b0011));
        check1("flush2_last", out_last, 1'b1);
        check("flush2_data", out_data, 128'h00000000_00000000_0000000B_0000000A);
        wait_drain();

        // Count-completed word carries the in_last of its final word
        sync();
        for (int i = 0; i < R; i++) send_word(IW'(32'h300 + i), (i == R - 1));
        wait_drain();

        // Single-word flush written while the held word drains
        sync();
        out_ready = 1'b0;
        for (int i = 0; i < R; i++) send_word(IW'(32'h400 + i), 1'b0);
        out_ready = 1'b1;
        send_word(32'hC, 1'b1);
        @(negedge clk);
        check1("drain_flush_valid", out_valid, 1'b1);
        check("drain_flush_keep", OW'(out_keep), OW'(4'b0001));
        check("drain_flush_data", out_data, 128'h0000000C);
        wait_drain();
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_packer.md
STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 Parameter IN_WIDTH, default 32: width of one input word.
REQ-002 Parameter RATIO, default 4: input words per output word; legal values are 2 to 16.
REQ-003 Derived OUT_WIDTH = IN_WIDTH*RATIO; it SHALL NOT be overridable.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_ready  output  1  packer can accept a word this cycle.
REQ-008 in_data  input  IN_WIDTH  upstream word.
REQ-009 in_last  input  1  last word of a packet; present only with STREAM_PACKER_LAST_EN.
REQ-010 out_valid  output  1  packed word valid.
REQ-011 out_ready  input  1  downstream accepts the packed word.
REQ-012 out_data  output  OUT_WIDTH  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
REQ-013 out_keep  output  RATIO  bit k set = lane k holds a written word; present only with the macro.
REQ-014 out_last  output  1  packed word closes a packet; present only with the macro.

Function
REQ-015 A transfer occurs on each port when valid and ready are both high at a rising clk edge; in_ready and out_ready combinationally affect nothing else.
REQ-016 in_ready SHALL equal (~out_valid | out_ready); no other term.
REQ-017 Internal lane counter cnt, range 0..RATIO-1, selects the lane written by the next accepted word; the first word of each output goes to lane 0 (LSBs).
REQ-018 Two states: FILL (out_valid=0) and HOLD (out_valid=1).
REQ-019 FILL, accepted word with cnt<RATIO-1: write lane cnt, cnt<=cnt+1, stay FILL.
REQ-020 FILL, accepted word with cnt=RATIO-1: write lane cnt, cnt<=0, go HOLD.
REQ-021 Latency: out_valid rises the cycle after the edge that accepts the completing word.
REQ-022 HOLD, out_ready=0: out_data, out_keep, out_last stable; in_ready=0; no state change.
REQ-023 HOLD, out_ready=1, no input transfer: go FILL with all lanes, keep and last cleared to 0.
REQ-024 HOLD, out_ready=1, simultaneous input transfer: the output is consumed and the word is written to lane 0 of a fresh word (other lanes 0, cnt<=1); if RATIO-completion or in_last applies to that word, stay HOLD.
REQ-025 Accepting a word into lane 0 SHALL clear all other lanes to 0; unwritten lanes always read 0.
REQ-026 Sustained throughput: one output per RATIO input cycles with no bubble when out_ready is held 1.
REQ-027 out_data is registered; no combinational path from in_data to out_data.

Reset
REQ-028 While rst_n=0: out_valid=0, out_data=0, cnt=0, state FILL; out_keep=0 and out_last=0 when present.
REQ-029 Reset asserted mid-fill or in HOLD discards the partial or held word; no output follows release.
REQ-030 in_ready SHALL read 1 during and immediately after reset.

Configuration
REQ-031 Macro STREAM_PACKER_LAST_EN: when defined, in_last, out_keep and out_last exist.
REQ-032 With the macro, an accepted word with in_last=1 completes the output regardless of cnt: go HOLD, cnt<=0, out_last=1, out_keep = bits 0..cnt set.
REQ-033 With the macro, a word completed by count alone has out_keep all ones and out_last equal to that word's in_last.
REQ-034 Without the macro, ports are absent; every output word is full and no partial flush exists.

Verification
REQ-035 IN_WIDTH=32, RATIO=4, out_ready=1, inputs 0x11,0x22,0x33,0x44 back to back -> one cycle later out_data=0x00000044_00000033_00000022_00000011, out_valid=1 for one cycle.
REQ-036 Continuous inputs 1..12 with out_ready=1 -> three outputs spaced 4 cycles apart; in_ready never drops.
REQ-037 out_ready=0 for 5 cycles after a full word -> in_ready=0 and out_data unchanged for all 5 cycles; the first input after out_ready=1 lands in lane 0.
REQ-038 Macro on: inputs 0xA, 0xB with in_last on 0xB -> out_keep=4'b0011, out_last=1, lanes 2-3 are 0.
REQ-039 Reset pulse after 2 of 4 words -> out_valid stays 0; the next 4 words produce one output with the first of them in lane 0.
REQ-040 Macro on: single input with in_last=1 while HOLD is drained the same cycle -> next output has out_keep=4'b0001 and out_valid stays 1 across the boundary.
